cache_sa: RTL and testbench

Parametrised set-associative, write-back, write-allocate data cache. It is the successor to the direct-mapped single-word cache. It sits between the datapath load/store unit and the memory model, and adds:
- multi-word lines
- N-way sets with round-robin replacement
- valid/ready handshakes on both sides, in place of a fixed done pulse

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_way.sv | 60 ++++++
 rtl/cache_sa.sv | 230 +++++++++++++++++++++++
 tb/tb_cache_sa.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the set-associative data cache.
//   state_t  - controller states
//   *_w()    - address field widths derived from the cache geometry
package cache_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOOKUP    = 3'd1,
      S_WRITEBACK = 3'd2,
      S_REFILL    = 3'd3,
      S_RESPOND   = 3'd4
   } state_t;

   function automatic int off_w();
      return 2;
   endfunction

   function automatic int word_w(input int words);
      return $clog2(words);
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int sets, input int words);
      return addr_w - off_w() - idx_w(sets) - word_w(words);
   endfunction

endpackage

// File: rtl/cache_way.sv
// cache_way: storage for one way of the cache (valid, dirty, tag, line data).
//   clk, reset          - clock, async active-low reset (clears valid/dirty)
//   rd_idx / rd_*       - combinational lookup port: full line plus metadata
//   wr_idx              - set addressed by the write port
//   wr_data_en/word/data- write one data word
//   wr_meta_en/valid/dirty/tag - update line metadata
module cache_way
   import cache_pkg::*;
#(
   parameter int SETS   = 256,
   parameter int WORDS  = 4,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 8,
   parameter int TAG_W  = 20,
   parameter int WSEL_W = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [IDX_W-1:0]             rd_idx,
   output logic                         rd_valid,
   output logic                         rd_dirty,
   output logic [TAG_W-1:0]             rd_tag,
   output logic [WORDS-1:0][DATA_W-1:0] rd_line,
   input  logic [IDX_W-1:0]             wr_idx,
   input  logic                         wr_data_en,
   input  logic [WSEL_W-1:0]            wr_word,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic                         wr_meta_en,
   input  logic                         wr_valid,
   input  logic                         wr_dirty,
   input  logic [TAG_W-1:0]             wr_tag
);

   logic [SETS-1:0]              valid;
   logic [SETS-1:0]              dirty;
   logic [TAG_W-1:0]             tags [SETS];
   logic [WORDS-1:0][DATA_W-1:0] data [SETS];

   assign rd_valid = valid[rd_idx];
   assign rd_dirty = dirty[rd_idx];
   assign rd_tag   = tags[rd_idx];
   assign rd_line  = data[rd_idx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= '0;
         dirty <= '0;
      end else if (wr_meta_en) begin
         valid[wr_idx] <= wr_valid;
         dirty[wr_idx] <= wr_dirty;
      end
   end

   // Tags and data are only meaningful under a valid bit, so they need no reset.
   always_ff @(posedge clk) begin
      if (wr_meta_en) tags[wr_idx] <= wr_tag;
      if (wr_data_en) data[wr_idx][wr_word] <= wr_data;
   end

endmodule

// File: rtl/cache_sa.sv
// cache_sa: set-associative, write-back, write-allocate data cache.
//   clk, reset                     - clock, async active-low reset
//   req_valid/ready/write/addr/wdata - CPU request (accepted in IDLE)
//   resp_valid/rdata/hit           - one-cycle completion pulse with data
//   mem_req/we/addr/wdata, mem_ack/rdata - registered beat interface to memory
module cache_sa
   import cache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SETS   = 256,
   parameter int WAYS   = 2,
   parameter int WORDS  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_hit,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int WORD_W = word_w(WORDS);
   localparam int IDX_W  = idx_w(SETS);
   localparam int TAG_W  = tag_w(ADDR_W, SETS, WORDS);
   localparam int WSEL_W = (WORD_W > 0) ? WORD_W : 1;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [WSEL_W-1:0] LAST = WSEL_W'(WORDS - 1);

   state_t              state;
   logic [ADDR_W-3:0]   r_waddr;
   logic                r_write;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_refilled;   // set for the re-lookup that follows a refill
   logic [WAY_W-1:0]    vic;
   logic [WSEL_W-1:0]   beat;
   logic [WAY_W-1:0]    rr [SETS];

   logic [IDX_W-1:0]    idx;
   logic [TAG_W-1:0]    tag;
   logic [WSEL_W-1:0]   word;

   logic [WAYS-1:0]              w_valid, w_dirty, hit_vec, we_data, we_meta;
   logic [TAG_W-1:0]             w_tag  [WAYS];
   logic [WORDS-1:0][DATA_W-1:0] w_line [WAYS];
   logic [WSEL_W-1:0]            wr_word;
   logic [DATA_W-1:0]            wr_data;
   logic                         wr_dirty;

   logic              any_hit, inv_found;
   logic [WAY_W-1:0]  hit_way, inv_way, vic_sel, rr_next;
   logic [WSEL_W-1:0] beat_nxt;

   logic unused_addr_lsb;
   assign unused_addr_lsb = ^req_addr[1:0];

   assign idx  = IDX_W'(r_waddr >> WORD_W);
   assign tag  = TAG_W'(r_waddr >> (WORD_W + IDX_W));
   assign word = (WORD_W == 0) ? '0 : WSEL_W'(r_waddr);
   assign beat_nxt = beat + 1'b1;

   assign req_ready  = reset && (state == S_IDLE);
   assign resp_valid = (state == S_RESPOND);

   function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                   input logic [IDX_W-1:0] i,
                                                   input logic [WSEL_W-1:0] b);
      logic [ADDR_W-1:0] a;
      a = (ADDR_W'(t) << (IDX_W + WORD_W + 2)) | (ADDR_W'(i) << (WORD_W + 2));
      if (WORD_W > 0) a = a | (ADDR_W'(b) << 2);
      return a;
   endfunction

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      cache_way #(
         .SETS(SETS), .WORDS(WORDS), .DATA_W(DATA_W),
         .IDX_W(IDX_W), .TAG_W(TAG_W), .WSEL_W(WSEL_W)
      ) u_way (
         .clk        (clk),
         .reset      (reset),
         .rd_idx     (idx),
         .rd_valid   (w_valid[g]),
         .rd_dirty   (w_dirty[g]),
         .rd_tag     (w_tag[g]),
         .rd_line    (w_line[g]),
         .wr_idx     (idx),
         .wr_data_en (we_data[g]),
         .wr_word    (wr_word),
         .wr_data    (wr_data),
         .wr_meta_en (we_meta[g]),
         .wr_valid   (1'b1),
         .wr_dirty   (wr_dirty),
         .wr_tag     (tag)
      );
      assign hit_vec[g] = w_valid[g] && (w_tag[g] == tag);
   end

   // Descending scan so the lowest-index match/invalid way wins.
   always_comb begin
      any_hit   = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int g = WAYS - 1; g >= 0; g--) begin
         if (hit_vec[g]) begin any_hit = 1'b1; hit_way = WAY_W'(g); end
         if (!w_valid[g]) begin inv_found = 1'b1; inv_way = WAY_W'(g); end
      end
      vic_sel = inv_found ? inv_way : rr[idx];
      rr_next = (rr[idx] == WAY_W'(WAYS - 1)) ? '0 : rr[idx] + 1'b1;
   end

   // A store miss is merged by the re-lookup after refill, which sees a store hit.
   always_comb begin
      we_data  = '0;
      we_meta  = '0;
      wr_word  = word;
      wr_data  = r_wdata;
      wr_dirty = 1'b1;
      case (state)
         S_LOOKUP: if (any_hit && r_write) begin
            we_data[hit_way] = 1'b1;
            we_meta[hit_way] = 1'b1;
         end
         S_REFILL: if (mem_ack) begin
            we_data[vic] = 1'b1;
            wr_word      = beat;
            wr_data      = mem_rdata;
            if (beat == LAST) begin
               we_meta[vic] = 1'b1;
               wr_dirty     = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < SETS; s++) rr[s] <= '0;
      end else if (state == S_LOOKUP && !any_hit && !inv_found) begin
         rr[idx] <= rr_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         r_waddr    <= '0;
         r_write    <= 1'b0;
         r_wdata    <= '0;
         r_refilled <= 1'b0;
         vic        <= '0;
         beat       <= '0;
         resp_rdata <= '0;
         resp_hit   <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         case (state)
            S_IDLE: if (req_valid) begin
               r_waddr    <= req_addr[ADDR_W-1:2];
               r_write    <= req_write;
               r_wdata    <= req_wdata;
               r_refilled <= 1'b0;
               state      <= S_LOOKUP;
            end
            S_LOOKUP: begin
               if (any_hit) begin
                  resp_rdata <= w_line[hit_way][word];
                  resp_hit   <= !r_refilled;
                  state      <= S_RESPOND;
               end else begin
                  vic     <= vic_sel;
                  beat    <= '0;
                  mem_req <= 1'b1;
                  if (w_valid[vic_sel] && w_dirty[vic_sel]) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= line_addr(w_tag[vic_sel], idx, '0);
                     mem_wdata <= w_line[vic_sel][0];
                     state     <= S_WRITEBACK;
                  end else begin
                     mem_we    <= 1'b0;
                     mem_addr  <= line_addr(tag, idx, '0);
                     mem_wdata <= '0;
                     state     <= S_REFILL;
                  end
               end
            end
            S_WRITEBACK: if (mem_ack) begin
               if (beat == LAST) begin
                  beat      <= '0;
                  mem_we    <= 1'b0;
                  mem_addr  <= line_addr(tag, idx, '0);
                  mem_wdata <= '0;
                  state     <= S_REFILL;
               end else begin
                  beat      <= beat_nxt;
                  mem_addr  <= line_addr(w_tag[vic], idx, beat_nxt);
                  mem_wdata <= w_line[vic][beat_nxt];
               end
            end
            S_REFILL: if (mem_ack) begin
               if (beat == LAST) begin
                  mem_req    <= 1'b0;
                  r_refilled <= 1'b1;
                  state      <= S_LOOKUP;
               end else begin
                  beat     <= beat_nxt;
                  mem_addr <= line_addr(tag, idx, beat_nxt);
               end
            end
            S_RESPOND: state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_sa.sv
// tb_cache_sa: directed, table-driven bench for cache_sa at default geometry.
// Memory returns addr ^ 0xA5A5_0000 and acks each beat after one wait cycle.
module tb_cache_sa;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_hit;
   logic [31:0] resp_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        hold;

   int tests = 0;
   int fails = 0;

   typedef struct packed { logic we; logic [31:0] a; logic [31:0] d; } beat_t;
   beat_t log_q[$];

   typedef struct {
      logic        wr;
      logic [31:0] addr, wdata, exp_rd;
      logic        chk_rd, exp_hit;
      int          exp_cyc;
      logic [31:0] wb, rf, sp_a, sp_d;
   } vec_t;
   vec_t v[13];

   always #5 clk = ~clk;

   cache_sa dut (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 mem_ack <= 1'b0;
      else if (mem_ack)           mem_ack <= 1'b0;
      else if (mem_req && !hold)  mem_ack <= 1'b1;
   end

   always @(posedge clk)
      if (rst_n && mem_req && mem_ack) log_q.push_back({mem_we, mem_addr, mem_wdata});

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic hit, output int cyc);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h1234_5678;
      cyc = 0;
      repeat (300) begin
         @(negedge clk);
         cyc++;
         if (resp_valid) break;
      end
      chk("resp_timeout", {31'b0, resp_valid}, 32'd1);
      rd  = resp_rdata;
      hit = resp_hit;
   endtask

   task automatic check_beats(input string nm, input logic [31:0] wb, input logic [31:0] rf,
                              input logic [31:0] sp_a, input logic [31:0] sp_d);
      int nwb, n;
      logic [31:0] ea, ed;
      nwb = (wb != 0) ? 4 : 0;
      n   = nwb + ((rf != 0) ? 4 : 0);
      chk({nm, "_nbeats"}, log_q.size(), n);
      for (int k = 0; k < n && k < log_q.size(); k++) begin
         if (k < nwb) begin
            ea = wb + 4 * k;
            ed = (ea == sp_a) ? sp_d : (ea ^ 32'hA5A5_0000);
            chk($sformatf("%s_wb%0d_we", nm, k), {31'b0, log_q[k].we}, 32'd1);
            chk($sformatf("%s_wb%0d_addr", nm, k), log_q[k].a, ea);
            chk($sformatf("%s_wb%0d_data", nm, k), log_q[k].d, ed);
         end else begin
            ea = rf + 4 * (k - nwb);
            chk($sformatf("%s_rf%0d_we", nm, k), {31'b0, log_q[k].we}, 32'd0);
            chk($sformatf("%s_rf%0d_addr", nm, k), log_q[k].a, ea);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, a0, d0;
      logic        hit;
      int          cyc, guard;

      //      wr   addr          wdata          exp_rd         chk hit cyc  wb            rf            sp_a          sp_d
      v[0]  = '{1'b0, 32'h0000_1040, 32'h0,         32'hA5A5_1040, 1'b1, 1'b0, 11, 32'h0,         32'h0000_1040, 32'h0,         32'h0};
      v[1]  = '{1'b0, 32'h0000_1040, 32'h0,         32'hA5A5_1040, 1'b1, 1'b1, 2,  32'h0,         32'h0,         32'h0,         32'h0};
      v[2]  = '{1'b1, 32'h0000_1044, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1, 2,  32'h0,         32'h0,         32'h0,         32'h0};
      v[3]  = '{1'b0, 32'h0000_1044, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b1, 2,  32'h0,         32'h0,         32'h0,         32'h0};
      v[4]  = '{1'b0, 32'h0000_2040, 32'h0,         32'hA5A5_2040, 1'b1, 1'b0, 11, 32'h0,         32'h0000_2040, 32'h0,         32'h0};
      v[5]  = '{1'b0, 32'h0000_3040, 32'h0,         32'hA5A5_3040, 1'b1, 1'b0, 19, 32'h0000_1040, 32'h0000_3040, 32'h0000_1044, 32'hDEAD_BEEF};
      v[6]  = '{1'b0, 32'h0000_2040, 32'h0,         32'hA5A5_2040, 1'b1, 1'b1, 2,  32'h0,         32'h0,         32'h0,         32'h0};
      v[7]  = '{1'b1, 32'h0000_5048, 32'hCAFE_F00D, 32'h0,         1'b0, 1'b0, 11, 32'h0,         32'h0000_5040, 32'h0,         32'h0};
      v[8]  = '{1'b0, 32'h0000_5048, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b1, 2,  32'h0,         32'h0,         32'h0,         32'h0};
      v[9]  = '{1'b0, 32'h0000_6040, 32'h0,         32'hA5A5_6040, 1'b1, 1'b0, 11, 32'h0,         32'h0000_6040, 32'h0,         32'h0};
      v[10] = '{1'b0, 32'h0000_7040, 32'h0,         32'hA5A5_7040, 1'b1, 1'b0, 19, 32'h0000_5040, 32'h0000_7040, 32'h0000_5048, 32'hCAFE_F00D};
      v[11] = '{1'b0, 32'h0000_604C, 32'h0,         32'hA5A5_604C, 1'b1, 1'b1, 2,  32'h0,         32'h0,         32'h0,         32'h0};
      v[12] = '{1'b0, 32'h0000_0010, 32'h0,         32'hA5A5_0010, 1'b1, 1'b0, 11, 32'h0,         32'h0000_0010, 32'h0,         32'h0};

      hold = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      rst_n = 1'b0;
      #1;
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_mem_req",   {31'b0, mem_req},   32'd0);
      chk("rst_resp_valid",{31'b0, resp_valid},32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_req_ready", {31'b0, req_ready}, 32'd1);

      for (int i = 0; i < 13; i++) begin
         log_q.delete();
         do_req(v[i].wr, v[i].addr, v[i].wdata, rd, hit, cyc);
         if (v[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, v[i].exp_rd);
         chk($sformatf("v%0d_hit", i), {31'b0, hit}, {31'b0, v[i].exp_hit});
         chk($sformatf("v%0d_cycles", i), cyc, v[i].exp_cyc);
         check_beats($sformatf("v%0d", i), v[i].wb, v[i].rf, v[i].sp_a, v[i].sp_d);
      end

      // Stalled beat: outputs must hold while mem_ack stays low.
      log_q.delete();
      hold = 1'b1;
      fork
         do_req(1'b0, 32'h0000_8010, 32'h0, rd, hit, cyc);
         begin
            guard = 0;
            @(negedge clk);
            while (!mem_req && guard < 20) begin @(negedge clk); guard++; end
            chk("hold_addr0", mem_addr, 32'h0000_8010);
            a0 = mem_addr; d0 = mem_wdata;
            repeat (10) begin
               @(negedge clk);
               chk("hold_req",   {31'b0, mem_req},   32'd1);
               chk("hold_addr",  mem_addr,  a0);
               chk("hold_wdata", mem_wdata, d0);
               chk("hold_ready", {31'b0, req_ready}, 32'd0);
            end
            hold = 1'b0;
         end
      join
      chk("hold_rdata", rd, 32'hA5A5_8010);
      chk("hold_hit", {31'b0, hit}, 32'd0);
      check_beats("hold", 32'h0, 32'h0000_8010, 32'h0, 32'h0);

      // Reset in the middle of the second refill beat.
      log_q.delete();
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_9020;
      @(posedge clk);
      #1 req_valid = 1'b0;
      guard = 0;
      while (log_q.size() < 1 && guard < 50) begin @(negedge clk); guard++; end
      chk("mid_beat1_addr", mem_addr, 32'h0000_9024);
      chk("mid_beat1_req",  {31'b0, mem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_mem_req",    {31'b0, mem_req},    32'd0);
      chk("mid_rst_mem_we",     {31'b0, mem_we},     32'd0);
      chk("mid_rst_mem_addr",   mem_addr,            32'd0);
      chk("mid_rst_mem_wdata",  mem_wdata,           32'd0);
      chk("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("mid_rst_resp_rdata", resp_rdata,          32'd0);
      chk("mid_rst_resp_hit",   {31'b0, resp_hit},   32'd0);
      chk("mid_rst_req_ready",  {31'b0, req_ready},  32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rel_req_ready", {31'b0, req_ready}, 32'd1);
      log_q.delete();
      do_req(1'b0, 32'h0000_9020, 32'h0, rd, hit, cyc);
      chk("post_rst_rdata",  rd, 32'hA5A5_9020);
      chk("post_rst_hit",    {31'b0, hit}, 32'd0);
      chk("post_rst_cycles", cyc, 11);
      check_beats("post_rst", 32'h0, 32'h0000_9020, 32'h0, 32'h0);
      // Earlier lines were invalidated by reset as well.
      log_q.delete();
      do_req(1'b0, 32'h0000_604C, 32'h0, rd, hit, cyc);
      chk("post_rst_old_hit", {31'b0, hit}, 32'd0);
      chk("post_rst_old_rdata", rd, 32'hA5A5_604C);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
